// File: rtl/pitch_pkg.sv
// Shared types and width helpers for the pitch-detect spectral path.
// Typedefs carry the default 24-bit / 1024-bin widths; parameterised blocks derive their own from mag_w().
package pitch_pkg;

    localparam int unsigned SAMPLE_W_DEF = 24;
    localparam int unsigned N_BINS_DEF   = 1024;

    // |X|^2 of a signed complex sample: two full-precision squares plus one carry bit.
    function automatic int unsigned mag_w(input int unsigned sample_w);
        return 2 * sample_w + 1;
    endfunction

    localparam int unsigned BIN_W_DEF = $clog2(N_BINS_DEF);
    localparam int unsigned MAG_W_DEF = mag_w(SAMPLE_W_DEF);

    typedef logic [BIN_W_DEF-1:0] bin_t;
    typedef logic [MAG_W_DEF-1:0] mag_t;

    typedef struct packed {
        bin_t bin;
        mag_t mag;
        logic found;
    } peak_result_t;

endpackage

// File: rtl/cmag_sq.sv
// Two-stage complex magnitude-squared pipeline with a valid/tag sideband.
// Each stage loads only when its incoming valid is set, so data holds across input gaps.
module cmag_sq
    import pitch_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned TAG_W    = 10,
    localparam int unsigned MAG_W   = mag_w(SAMPLE_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] re,
    input  logic signed [SAMPLE_W-1:0] im,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [MAG_W-1:0]           mag,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int unsigned SQ_W = 2 * SAMPLE_W;

    logic signed [SQ_W-1:0] re_ext;
    logic signed [SQ_W-1:0] im_ext;
    logic [SQ_W-1:0]        re_sq;
    logic [SQ_W-1:0]        im_sq;
    logic                   s1_valid;
    logic [TAG_W-1:0]       s1_tag;

    // Sign-extend first so the product is computed at full 2W width.
    assign re_ext = {{SAMPLE_W{re[SAMPLE_W-1]}}, re};
    assign im_ext = {{SAMPLE_W{im[SAMPLE_W-1]}}, im};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            re_sq     <= '0;
            im_sq     <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            mag       <= '0;
            out_tag   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                re_sq  <= re_ext * re_ext;
                im_sq  <= im_ext * im_ext;
                s1_tag <= in_tag;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                mag     <= MAG_W'(re_sq) + MAG_W'(im_sq);
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: rtl/spectral_peak_finder.sv
// Per-frame strongest-bin search over a fixed window with a runtime noise threshold.
// Build option: define PEAK_HOLD_EN to repeat the last above-threshold peak when a frame finds none.
module spectral_peak_finder
    import pitch_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned N_BINS   = 1024,
    parameter int unsigned MIN_BIN  = 1,
    parameter int unsigned MAX_BIN  = 511,
    localparam int unsigned BIN_W   = $clog2(N_BINS),
    localparam int unsigned MAG_W   = mag_w(SAMPLE_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fft_bins_valid,
    output logic                  fft_bins_ready,
    input  logic [2*SAMPLE_W-1:0] fft_bins_data,
    output logic                  peak_valid,
    input  logic                  peak_ready,
    output logic [BIN_W-1:0]      peak_data,
    output logic [MAG_W-1:0]      peak_mag,
    output logic                  peak_found,
    input  logic [MAG_W-1:0]      thresh,
    output logic                  overrun
);

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic [MAG_W-1:0] mag;
        logic             found;
    } result_t;

    localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] MAX_IDX  = BIN_W'(MAX_BIN);
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_BINS - 1);

    logic [BIN_W-1:0] bin_cnt;
    logic [MAG_W-1:0] thresh_lat;
    logic [MAG_W-1:0] thresh_s3;
    logic             s2_valid;
    logic [MAG_W-1:0] s2_mag;
    logic [BIN_W-1:0] s2_idx;
    logic [BIN_W-1:0] max_bin;
    logic [MAG_W-1:0] max_mag;
    logic             frame_done;
    logic [BIN_W-1:0] base_bin_c;
    logic [MAG_W-1:0] base_mag_c;
    logic [BIN_W-1:0] next_bin_c;
    logic [MAG_W-1:0] next_mag_c;
    result_t          res_c;

    assign fft_bins_ready = 1'b1;

    // Bin counter and threshold capture at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_cnt    <= '0;
            thresh_lat <= '0;
        end else if (fft_bins_valid) begin
            bin_cnt <= bin_cnt + BIN_W'(1);
            if (bin_cnt == '0) begin
                thresh_lat <= thresh;
            end
        end
    end

    cmag_sq #(
        .SAMPLE_W (SAMPLE_W),
        .TAG_W    (BIN_W)
    ) u_cmag_sq (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fft_bins_valid),
        .re        (fft_bins_data[2*SAMPLE_W-1:SAMPLE_W]),
        .im        (fft_bins_data[SAMPLE_W-1:0]),
        .in_tag    (bin_cnt),
        .out_valid (s2_valid),
        .mag       (s2_mag),
        .out_tag   (s2_idx)
    );

    // S3 compare: bin 0 restarts the search; strict > keeps the lowest index on ties.
    always_comb begin
        base_bin_c = max_bin;
        base_mag_c = max_mag;
        if (s2_idx == '0) begin
            base_bin_c = MIN_IDX;
            base_mag_c = '0;
        end
        next_bin_c = base_bin_c;
        next_mag_c = base_mag_c;
        if ((s2_idx >= MIN_IDX) && (s2_idx <= MAX_IDX) && (s2_mag > base_mag_c)) begin
            next_bin_c = s2_idx;
            next_mag_c = s2_mag;
        end
    end

    // thresh_s3 follows the frame down the pipe so the next frame's bin 0 cannot clobber it early.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_bin    <= '0;
            max_mag    <= '0;
            thresh_s3  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= s2_valid && (s2_idx == LAST_IDX);
            if (s2_valid) begin
                max_bin <= next_bin_c;
                max_mag <= next_mag_c;
                if (s2_idx == '0) begin
                    thresh_s3 <= thresh_lat;
                end
            end
        end
    end

`ifdef PEAK_HOLD_EN
    logic [BIN_W-1:0] hold_bin;
    logic [MAG_W-1:0] hold_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_bin <= '0;
            hold_mag <= '0;
        end else if (frame_done && res_c.found) begin
            hold_bin <= max_bin;
            hold_mag <= max_mag;
        end
    end

    always_comb begin
        res_c.found = (max_mag > thresh_s3);
        res_c.bin   = res_c.found ? max_bin : hold_bin;
        res_c.mag   = res_c.found ? max_mag : hold_mag;
    end
`else
    always_comb begin
        res_c.found = (max_mag > thresh_s3);
        res_c.bin   = max_bin;
        res_c.mag   = max_mag;
    end
`endif

    // Output register: a new result overwrites a stalled one and flags overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_valid <= 1'b0;
            peak_data  <= '0;
            peak_mag   <= '0;
            peak_found <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            peak_valid <= 1'b1;
            peak_data  <= res_c.bin;
            peak_mag   <= res_c.mag;
            peak_found <= res_c.found;
            if (peak_valid && !peak_ready) begin
                overrun <= 1'b1;
            end
        end else if (peak_ready) begin
            peak_valid <= 1'b0;
        end
    end

endmodule
